// File: rtl/mem_wb_elastic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_elastic_pipe
//  Purpose  : Elastic valid/ready pipeline register (STAGES slots) with flush
//             and bubble-masked write enable; optional skid entry enabled by
//             defining MEM_WB_PIPE_SKID_EN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wb_elastic_pipe #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_wen,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_wen,
  output logic [2:0]        occ
);

  localparam int HEAD = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wen_q, wen_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];
  logic [CTRL_W-1:0] ctrl_q [STAGES];
  logic [CTRL_W-1:0] ctrl_d [STAGES];

  logic [STAGES-1:0] slot_free;
  logic [STAGES-1:0] slot_adv;
  logic              accept;
  logic              load0;
  logic [DATA_W-1:0] src_data;
  logic [CTRL_W-1:0] src_ctrl;
  logic              src_wen;
  logic              skid_cnt;

  // Freedom ripples from the head backwards, so a full pipe still moves
  // in lock-step whenever the head is consumed.
  always_comb begin
    slot_free = '0;
    slot_adv  = '0;
    slot_adv[HEAD]  = valid_q[HEAD] & out_ready;
    slot_free[HEAD] = ~valid_q[HEAD] | slot_adv[HEAD];
    for (int k = STAGES - 2; k >= 0; k--) begin
      slot_adv[k]  = valid_q[k] & slot_free[k+1];
      slot_free[k] = ~valid_q[k] | slot_adv[k];
    end
  end

`ifdef MEM_WB_PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              skid_wen_q, skid_wen_d;

  assign in_ready = ~skid_valid_q;
  assign skid_cnt = skid_valid_q;

  always_comb begin
    accept       = in_valid & in_ready;
    load0        = slot_free[0] & (skid_valid_q | accept);
    src_data     = skid_valid_q ? skid_data_q : in_data;
    src_ctrl     = skid_valid_q ? skid_ctrl_q : in_ctrl;
    src_wen      = skid_valid_q ? skid_wen_q  : in_wen;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_wen_d   = skid_wen_q;
    // The parked entry always drains before anything new is taken.
    if (skid_valid_q && slot_free[0]) begin
      skid_valid_d = 1'b0;
    end else if (accept && !slot_free[0]) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
      skid_wen_d   = in_wen;
    end
    if (flush) skid_valid_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
      skid_wen_q   <= 1'b0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_wen_q   <= skid_wen_d;
    end
  end
`else
  assign in_ready = slot_free[0];
  assign skid_cnt = 1'b0;

  always_comb begin
    accept   = in_valid & in_ready;
    load0    = accept;
    src_data = in_data;
    src_ctrl = in_ctrl;
    src_wen  = in_wen;
  end
`endif

  // Vacated slots drop their valid bit; payload is left stale.
  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    for (int k = 0; k < STAGES; k++) begin
      if (slot_adv[k]) valid_d[k] = 1'b0;
    end
    if (load0) begin
      valid_d[0] = 1'b1;
      data_d[0]  = src_data;
      ctrl_d[0]  = src_ctrl;
      wen_d[0]   = src_wen;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (slot_adv[k-1]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = data_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        wen_d[k]   = wen_q[k-1];
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      wen_q   <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
        ctrl_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    occ = {2'b00, skid_cnt};
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + {2'b00, valid_q[k]};
    end
  end

  assign out_valid = valid_q[HEAD];
  assign out_data  = data_q[HEAD];
  assign out_ctrl  = ctrl_q[HEAD];
  assign out_wen   = wen_q[HEAD] & valid_q[HEAD];

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_elastic_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_elastic_pipe
//  Purpose  : Directed self-checking bench for mem_wb_elastic_pipe, STAGES=3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_wb_elastic_pipe;

  localparam int STAGES = 3;
`ifdef MEM_WB_PIPE_SKID_EN
  localparam int CAP = STAGES + 1;
`else
  localparam int CAP = STAGES;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wen;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wen;
  logic [2:0]  occ;

  int errors = 0;
  int checks = 0;

  mem_wb_elastic_pipe #(.DATA_W(32), .CTRL_W(8), .STAGES(STAGES)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_wen    (in_wen),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_wen   (out_wen),
    .occ       (occ)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int acc, cons, sent, exp_next, cnt;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_ctrl = 8'hFF; in_wen = 1'b1;

    // Reset with a valid input pending
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_wen", out_wen, 0);
    check("rst_occ", occ, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_emerge", out_valid, 0);
    end

    // Streaming 0x1..0x8 at full rate
    for (int c = 0; c <= 10; c++) begin
      in_valid = (c < 8);
      in_data  = 32'(c + 1);
      in_ctrl  = 8'(c + 1) ^ 8'h5A;
      in_wen   = 1'b1;
      #1;
      if (c < 8) check("stream_in_ready", in_ready, 1);
      tick();
      acc  = (c + 1 < 8) ? c + 1 : 8;
      cons = (c - 2 > 0) ? ((c - 2 < 8) ? c - 2 : 8) : 0;
      check("stream_occ", occ, 32'(acc - cons));
      check("stream_valid", out_valid, (c >= 2 && c <= 9) ? 1 : 0);
      if (c >= 2 && c <= 9) begin
        check("stream_data", out_data, 32'(c - 1));
        check("stream_ctrl", out_ctrl, 32'(8'(c - 1) ^ 8'h5A));
        check("stream_wen", out_wen, 1);
      end
    end
    in_valid = 1'b0;

    // Backpressure: fill to capacity, then release
    out_ready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h10 + 32'(cnt);
      in_ctrl  = 8'h00;
      #1;
      check("bp_in_ready", in_ready, (cnt < CAP) ? 1 : 0);
      tick();
      if (cnt < CAP) cnt++;
      check("bp_occ", occ, 32'(cnt));
    end
    check("bp_head", out_data, 32'h10);
    out_ready = 1'b1;
    sent = cnt; exp_next = 32'h10;
    for (int c = 0; c < 10; c++) begin
      in_valid = (sent < 5);
      in_data  = 32'h10 + 32'(sent);
      #1;
      if (out_valid) begin
        check("bp_order", out_data, 32'(exp_next));
        exp_next++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_all_out", 32'(exp_next), 32'h15);
    check("bp_empty", occ, 0);

    // Bubble masking: one write entry, one non-write entry, then idle
    in_valid = 1'b1; in_data = 32'h55; in_wen = 1'b1;
    tick();
    in_data = 32'h66; in_wen = 1'b0;
    tick();
    in_valid = 1'b0; in_wen = 1'b1;
    check("bub_pre_wen", out_wen, 0);
    tick();
    check("bub_valid", out_valid, 1);
    check("bub_data", out_data, 32'h55);
    check("bub_wen", out_wen, 1);
    tick();
    check("bub_nowen_data", out_data, 32'h66);
    check("bub_nowen_wen", out_wen, 0);
    tick();
    check("bub_idle_valid", out_valid, 0);
    check("bub_idle_wen", out_wen, 0);
    tick();
    check("bub_idle2_wen", out_wen, 0);

    // Flush while accepting 0xA3
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hA0 + 32'(i);
      tick();
    end
    check("fl_full", occ, 3);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hA3;
    #1;
    check("fl_in_ready", in_ready, 1);
    check("fl_cur_valid", out_valid, 1);
    check("fl_cur_data", out_data, 32'hA0);
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 32'hB0;
    check("fl_occ", occ, 0);
    check("fl_valid", out_valid, 0);
    tick();
    in_valid = 1'b0;
    check("fl_lat1", out_valid, 0);
    tick();
    check("fl_lat2", out_valid, 0);
    tick();
    check("fl_b0_valid", out_valid, 1);
    check("fl_b0_data", out_data, 32'hB0);
    tick();
    check("fl_drained", occ, 0);

    // Flush and reset together with an entry held at the head
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC0; in_ctrl = 8'h3C; in_wen = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("fr_held", out_data, 32'hC0);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 32'hD0;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("fr_valid", out_valid, 0);
    check("fr_data", out_data, 0);
    check("fr_ctrl", out_ctrl, 0);
    check("fr_wen", out_wen, 0);
    check("fr_occ", occ, 0);
    check("fr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("fr_no_emerge", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_wb_elastic_pipe.md
# mem_wb_elastic_pipe

Parametrised elastic pipeline register for the MEM→WB boundary and any other stage boundary in the CPU. It carries a data payload, a control bundle and a register-file write enable across STAGES register slots with a valid/ready handshake, synchronous flush and bubble masking. It supersedes fixed, always-advancing stage registers: it stalls without losing data, and an invalid slot never drives a write enable.

## Interface
Parameters:
- DATA_W, 32: payload width (result, load data, PC+4 packed by the instantiating level).
- CTRL_W, 8: control bundle width (mux selects, link flag, destination register).
- STAGES, 1: number of register slots in series, legal range 1..4.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  block accepts an entry this cycle.
- in_data  in  DATA_W  payload.
- in_ctrl  in  CTRL_W  control bundle.
- in_wen  in  1  register-file write enable for this entry.
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head entry.
- out_data  out  DATA_W  head payload.
- out_ctrl  out  CTRL_W  head control.
- out_wen  out  1  head write enable, ANDed with out_valid.
- occ  out  3  number of valid entries held, including the skid entry.

## Operation
- Each slot holds a valid bit, data, ctrl and wen. Slot 0 is the input side. Slot STAGES-1 is the head.
- A slot is free when its valid bit is 0 or when it is advancing this cycle.
- The head advances when out_valid & out_ready. Slot k advances into slot k+1 when slot k+1 is free.
- Accept = in_valid & in_ready. An accepted entry loads slot 0.
- Without skid: in_ready = slot 0 free. This is a combinational path from out_ready.
- A slot whose contents move on and that receives no new entry clears its valid bit. Its data/ctrl/wen hold their old value (don't-care).
- out_data, out_ctrl and out_wen come straight from the head registers. out_wen = head.wen & head.valid, so a bubble never writes the register file.
- occ counts the set valid bits, range 0..STAGES (+1 with skid).
- Flush: at the next edge every valid bit clears, including skid. An entry accepted in the flush cycle is dropped. out_valid during the flush cycle still reflects current state, and a head consumed in that cycle counts as delivered.
- Reset (synchronous): all valid bits, data, ctrl and wen registers clear to 0. Reset has priority over flush and accept.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_ctrl = 0, out_wen = 0, occ = 0.
- Latency: an entry accepted at edge N appears at the head after edge N+STAGES-1. It is visible on out_valid in the cycle after that edge, i.e. STAGES cycles when the pipe is unobstructed.
- Throughput: one entry per cycle while out_ready = 1.
- Stall: with out_ready = 0 the pipe fills to STAGES entries (STAGES+1 with skid), then in_ready falls. No entry is lost or duplicated.
- Every slot is free while out_ready stays high: full pipe + simultaneous accept + consume keeps occ constant.
- Ordering: strictly FIFO.

## Configuration
- MEM_WB_PIPE_SKID_EN defined:
  - Adds a one-entry skid register in front of slot 0.
  - in_ready becomes a registered signal: 1 when the skid entry is empty.
  - When slot 0 cannot take an accepted entry, the entry is parked in skid. It drains into slot 0 before any new input.
  - Capacity is STAGES+1. Latency is unchanged when unobstructed.
  - No combinational path from out_ready to in_ready.
- Not defined: no skid register; in_ready is combinational as described in Operation; capacity is STAGES.

## Test plan
- Reset: assert reset for 2 cycles with in_valid = 1, in_data = 0xDEADBEEF → out_valid = 0, out_wen = 0, occ = 0, in_ready = 1; no entry emerges afterwards.
- Streaming, STAGES = 3: send 0x1..0x8 back-to-back with out_ready = 1 → first output 3 cycles after first accept; 0x1..0x8 in order at one per cycle; occ steady at 3.
- Backpressure: hold out_ready = 0 and send 0x10..0x14 → in_ready drops after STAGES (STAGES+1 with skid) accepts. Release → entries emerge in order, none lost.
- Bubble masking: entry with in_wen = 1, then 2 idle cycles → out_wen is high only during that entry's valid cycle, 0 during bubbles.
- Flush: fill the pipe with 0xA0..0xA2, pulse flush together with accepting 0xA3 → occ = 0 next cycle; 0xA3 never appears; the next entry 0xB0 arrives with normal latency.
- Flush + reset in the same cycle, with an entry held → all state cleared; behaviour identical to reset alone.
